arbiter_request_queue: RTL and testbench

ARBITER_REQUEST_QUEUE -- requirements
Module: arbiter_request_queue

---
 rtl/arb_pkg.sv | 8 +
 rtl/arq_fifo.sv | 41 ++++
 rtl/arbiter_request_queue.sv | 65 ++++++
 tb/tb_arbiter_request_queue.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared defaults and source-id type for the request queue and round-robin arbiter
package arb_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_DATA_W = 8;
  localparam int SRC_W = $clog2(DEF_NUM_REQ);
  typedef logic [SRC_W-1:0] src_t;
endpackage

// File: rtl/arq_fifo.sv
// arq_fifo: single-channel synchronous FIFO with simultaneous push/pop on a full queue
import arb_pkg::*;
module arq_fifo #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/arbiter_request_queue.sv
// arbiter_request_queue: per-requester FIFOs feeding an external arbiter, popped by one-hot grant
import arb_pkg::*;
module arbiter_request_queue #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DEPTH = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        wr_en,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  output logic [NUM_REQ-1:0]        full,
  output logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ-1:0]        GNT,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output src_t                      out_src,
  output logic [NUM_REQ-1:0]        err_ovf,
  output logic                      err_gnt
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [NUM_REQ-1:0] pop, empty;
  logic [CW-1:0] count [NUM_REQ];
  logic [DATA_W-1:0] head [NUM_REQ];
  logic multi, one_hot;
  src_t sel;
  assign multi = (GNT & (GNT - NUM_REQ'(1))) != '0;
  assign one_hot = |GNT && !multi;
  assign REQ = ~empty;
  for (genvar g = 0; g < NUM_REQ; g++) begin : ch
    assign pop[g] = one_hot && GNT[g] && count[g] != '0;
    arq_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(wr_en[g]),
      .pop(pop[g]),
      .din(wr_data[g*DATA_W +: DATA_W]),
      .dout(head[g]),
      .count(count[g]),
      .full(full[g]),
      .empty(empty[g])
    );
  end
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) sel = GNT[i] ? src_t'(i) : sel;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_src <= '0;
      err_ovf <= '0;
      err_gnt <= 1'b0;
    end else begin
      out_valid <= |pop;
      err_gnt <= multi;
      err_ovf <= err_ovf | (wr_en & full & ~pop);
      if (|pop) begin
        out_data <= head[sel];
        out_src <= sel;
      end
    end
  end
endmodule

// File: tb/tb_arbiter_request_queue.sv
// tb_arbiter_request_queue: directed self-checking bench for the request queue
module tb_arbiter_request_queue;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] wr_en;
  logic [31:0] wr_data;
  logic [3:0] full, REQ, GNT;
  logic out_valid;
  logic [7:0] out_data;
  logic [1:0] out_src;
  logic [3:0] err_ovf;
  logic err_gnt;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  arbiter_request_queue dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .full(full),
    .REQ(REQ),
    .GNT(GNT),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_src(out_src),
    .err_ovf(err_ovf),
    .err_gnt(err_gnt)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push1(input int ch, input logic [7:0] d);
    wr_en = 4'b0;
    wr_en[ch] = 1'b1;
    wr_data = '0;
    wr_data[ch*8 +: 8] = d;
    tick();
    wr_en = 4'b0;
  endtask
  task automatic pop_check(input string tag, input logic [7:0] d, input logic [1:0] s);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(d));
    check({tag, "_src"}, 32'(out_src), 32'(s));
  endtask
  initial begin
    rst = 1'b1;
    wr_en = '0;
    wr_data = '0;
    GNT = '0;
    tick();
    check("rst_req", 32'(REQ), 32'h0);
    check("rst_full", 32'(full), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_src", 32'(out_src), 32'h0);
    check("rst_ovf", 32'(err_ovf), 32'h0);
    check("rst_gnt", 32'(err_gnt), 32'h0);
    rst = 1'b0;
    // scenario 1
    push1(2, 8'hA1);
    push1(2, 8'hA2);
    check("s1_req", 32'(REQ), 32'b0100);
    GNT = 4'b0100;
    tick();
    pop_check("s1_pop1", 8'hA1, 2'd2);
    tick();
    pop_check("s1_pop2", 8'hA2, 2'd2);
    check("s1_req_empty", 32'(REQ), 32'b0000);
    GNT = 4'b0000;
    tick();
    check("s1_idle_valid", 32'(out_valid), 32'h0);
    check("s1_hold_data", 32'(out_data), 32'hA2);
    check("s1_hold_src", 32'(out_src), 32'h2);
    // scenario 2
    for (int i = 0; i < 4; i++) push1(0, 8'(8'h10 + i));
    check("s2_full", 32'(full), 32'b0001);
    check("s2_no_ovf", 32'(err_ovf), 32'h0);
    push1(0, 8'h14);
    check("s2_ovf", 32'(err_ovf), 32'b0001);
    check("s2_full_kept", 32'(full), 32'b0001);
    // scenario 3
    for (int i = 0; i < 4; i++) push1(1, 8'(8'h20 + i));
    check("s3_full", 32'(full), 32'b0011);
    wr_en = 4'b0010;
    wr_data = 32'h0000_5500;
    GNT = 4'b0010;
    tick();
    wr_en = '0;
    GNT = '0;
    pop_check("s3_pop", 8'h20, 2'd1);
    check("s3_full_kept", 32'(full), 32'b0011);
    check("s3_ovf", 32'(err_ovf), 32'b0001);
    // scenario 4
    GNT = 4'b0011;
    tick();
    check("s4_valid", 32'(out_valid), 32'h0);
    check("s4_err_gnt", 32'(err_gnt), 32'h1);
    check("s4_full", 32'(full), 32'b0011);
    GNT = 4'b0000;
    tick();
    check("s4_err_gnt_clr", 32'(err_gnt), 32'h0);
    check("s4_zero_valid", 32'(out_valid), 32'h0);
    GNT = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      pop_check("s2_drain", 8'(8'h10 + i), 2'd0);
    end
    check("s2_drained_req", 32'(REQ), 32'b0010);
    tick();
    check("s2_empty_valid", 32'(out_valid), 32'h0);
    check("s2_empty_hold", 32'(out_data), 32'h13);
    GNT = 4'b0010;
    tick();
    GNT = 4'b0000;
    pop_check("s3_next", 8'h21, 2'd1);
    // scenario 5
    GNT = 4'b1000;
    tick();
    check("s5_empty_valid", 32'(out_valid), 32'h0);
    wr_en = 4'b1000;
    wr_data = 32'h7700_0000;
    tick();
    wr_en = '0;
    check("s5_req_rise", 32'(REQ), 32'b1010);
    check("s5_no_pop_yet", 32'(out_valid), 32'h0);
    tick();
    pop_check("s5_pop", 8'h77, 2'd3);
    check("s5_req_fall", 32'(REQ), 32'b0010);
    GNT = 4'b0000;
    // scenario 6
    push1(0, 8'h31);
    push1(2, 8'h32);
    check("s6_req_pre", 32'(REQ), 32'b0111);
    rst = 1'b1;
    wr_en = 4'b1111;
    wr_data = 32'hDEAD_BEEF;
    GNT = 4'b0010;
    tick();
    check("s6_req", 32'(REQ), 32'h0);
    check("s6_full", 32'(full), 32'h0);
    check("s6_valid", 32'(out_valid), 32'h0);
    check("s6_data", 32'(out_data), 32'h0);
    check("s6_src", 32'(out_src), 32'h0);
    check("s6_ovf", 32'(err_ovf), 32'h0);
    check("s6_err_gnt", 32'(err_gnt), 32'h0);
    rst = 1'b0;
    wr_en = '0;
    tick();
    check("s6_discard_valid", 32'(out_valid), 32'h0);
    check("s6_discard_req", 32'(REQ), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
